// File: rtl/prio_scan_pkg.sv
// Shared types and helpers for the priority scan encoder.
package prio_scan_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    // Index width for a vector of the given width, never below one bit.
    function automatic int idx_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/prio_pick.sv
// Combinational find-first-set with selectable priority direction.
// Also reports whether exactly one bit is set.
module prio_pick #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter int IDX_W     = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] vec,
    output logic [IDX_W-1:0] index,
    output logic             found,
    output logic             single
);

    // Scan toward the highest-priority end so the last hit wins.
    always_comb begin
        index  = '0;
        found  = 1'b0;
        if (MSB_FIRST) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (vec[i]) begin
                    index = IDX_W'(i);
                    found = 1'b1;
                end
            end
        end else begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (vec[i]) begin
                    index = IDX_W'(i);
                    found = 1'b1;
                end
            end
        end
        // Clearing the lowest set bit leaves zero only when one bit was set.
        single = found && ((vec & (vec - WIDTH'(1))) == '0);
    end

endmodule

// File: rtl/prio_scan_encoder.sv
// Registered priority encoder: captures a request vector and streams the
// index of each set bit, one per handshake, in priority order.
//
//   state | meaning
//   IDLE  | ready for a new vector; working register is empty
//   SCAN  | emitting indices from the working register
module prio_scan_encoder
    import prio_scan_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter int IDX_W     = idx_width(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_index,
    output logic             out_last,
    output logic             out_none,
    output logic [IDX_W:0]   remaining
);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic               none_q, none_d;

    logic [IDX_W-1:0]   pick_index;
    logic               pick_found;
    logic               pick_single;

    prio_pick #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST),
        .IDX_W     (IDX_W)
    ) u_pick (
        .vec    (work_q),
        .index  (pick_index),
        .found  (pick_found),
        .single (pick_single)
    );

    // Next-state, working-register update and handshake outputs.
    always_comb begin
        state_d   = state_q;
        work_d    = work_q;
        none_d    = 1'b0;
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == SCAN) && pick_found;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (in_data != '0) begin
                        work_d  = in_data;
                        state_d = SCAN;
                    end else begin
                        none_d = 1'b1;
                    end
                end
            end
            SCAN: begin
                if (out_ready) begin
                    work_d = work_q & ~(WIDTH'(1) << pick_index);
                    if (pick_single) begin
                        state_d = IDLE;
                    end
                end
            end
        endcase
    end

    // Popcount of the working register; zero while idle.
    always_comb begin
        remaining = '0;
        for (int i = 0; i < WIDTH; i++) begin
            remaining = remaining + (IDX_W+1)'(work_q[i]);
        end
    end

    assign out_index = pick_index;
    assign out_last  = pick_single;
    assign out_none  = none_q;

    // State, working register and empty-vector pulse; reset wins over handshakes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            work_q  <= '0;
            none_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            none_q  <= none_d;
        end
    end

endmodule

// File: tb/tb_prio_scan_encoder.sv
// Bench for prio_scan_encoder: three instances (8-bit MSB-first, 8-bit
// LSB-first, 16-bit MSB-first) driven from a shared task.
module tb_prio_scan_encoder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] in_data = '0;
    logic        iv [3];
    logic        ordy [3];

    logic        a_in_ready, a_out_valid, a_out_last, a_out_none;
    logic [2:0]  a_out_index;
    logic [3:0]  a_remaining;
    logic        b_in_ready, b_out_valid, b_out_last, b_out_none;
    logic [2:0]  b_out_index;
    logic [3:0]  b_remaining;
    logic        c_in_ready, c_out_valid, c_out_last, c_out_none;
    logic [3:0]  c_out_index;
    logic [4:0]  c_remaining;

    int checks = 0;
    int errors = 0;
    int sel = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    prio_scan_encoder #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb8 (
        .clk(clk), .reset(reset), .in_valid(iv[0]), .in_ready(a_in_ready),
        .in_data(in_data[7:0]), .out_valid(a_out_valid), .out_ready(ordy[0]),
        .out_index(a_out_index), .out_last(a_out_last), .out_none(a_out_none),
        .remaining(a_remaining)
    );

    prio_scan_encoder #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb8 (
        .clk(clk), .reset(reset), .in_valid(iv[1]), .in_ready(b_in_ready),
        .in_data(in_data[7:0]), .out_valid(b_out_valid), .out_ready(ordy[1]),
        .out_index(b_out_index), .out_last(b_out_last), .out_none(b_out_none),
        .remaining(b_remaining)
    );

    prio_scan_encoder #(.WIDTH(16), .MSB_FIRST(1'b1)) u_msb16 (
        .clk(clk), .reset(reset), .in_valid(iv[2]), .in_ready(c_in_ready),
        .in_data(in_data), .out_valid(c_out_valid), .out_ready(ordy[2]),
        .out_index(c_out_index), .out_last(c_out_last), .out_none(c_out_none),
        .remaining(c_remaining)
    );

    // Uniform view of whichever instance is under test.
    logic       v_in_ready, v_out_valid, v_out_last, v_out_none;
    logic [4:0] v_index, v_rem;
    always_comb begin
        case (sel)
            1: begin
                v_in_ready = b_in_ready; v_out_valid = b_out_valid;
                v_out_last = b_out_last; v_out_none = b_out_none;
                v_index = {2'b0, b_out_index}; v_rem = {1'b0, b_remaining};
            end
            2: begin
                v_in_ready = c_in_ready; v_out_valid = c_out_valid;
                v_out_last = c_out_last; v_out_none = c_out_none;
                v_index = {1'b0, c_out_index}; v_rem = c_remaining;
            end
            default: begin
                v_in_ready = a_in_ready; v_out_valid = a_out_valid;
                v_out_last = a_out_last; v_out_none = a_out_none;
                v_index = {2'b0, a_out_index}; v_rem = {1'b0, a_remaining};
            end
        endcase
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: list set bits in priority order from the rules alone.
    task automatic build_exp(input logic [15:0] vec, input int w, input bit msb);
        exp_q.delete();
        for (int p = 0; p < w; p++) begin
            int b;
            b = msb ? (w - 1 - p) : p;
            if (vec[b]) exp_q.push_back(b);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, " in_ready"}, int'(v_in_ready), 1);
        check({tag, " out_valid"}, int'(v_out_valid), 0);
        check({tag, " remaining"}, int'(v_rem), 0);
    endtask

    // Present one vector to instance s and consume it, checking every cycle.
    task automatic run_vec(input int s, input logic [15:0] vec, input int stall_first,
                           input bit rnd_ready, input bit junk,
                           output int first_idx, output int n_hs);
        int w;
        bit msb;
        int guard;
        bit rdy;
        w = (s == 2) ? 16 : 8;
        msb = (s != 1);
        first_idx = -1;
        n_hs = 0;
        sel = s;
        build_exp(vec, w, msb);
        @(negedge clk);
        check_idle("pre");
        in_data = vec;
        iv[s] = 1'b1;
        @(negedge clk);
        iv[s] = 1'b0;
        if (exp_q.size() == 0) begin
            check("none pulse", int'(v_out_none), 1);
            check("none valid", int'(v_out_valid), 0);
            check("none in_ready", int'(v_in_ready), 1);
            @(negedge clk);
            check("none cleared", int'(v_out_none), 0);
            check("none valid2", int'(v_out_valid), 0);
            check("none in_ready2", int'(v_in_ready), 1);
            return;
        end
        guard = 0;
        while (exp_q.size() > 0 && guard < 300) begin
            guard++;
            check("scan valid", int'(v_out_valid), 1);
            check("scan in_ready", int'(v_in_ready), 0);
            check("scan index", int'(v_index), exp_q[0]);
            check("scan last", int'(v_out_last), int'(exp_q.size() == 1));
            check("scan remaining", int'(v_rem), exp_q.size());
            check("scan none", int'(v_out_none), 0);
            if (stall_first > 0) begin
                rdy = 1'b0;
                stall_first--;
            end else begin
                rdy = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            ordy[s] = rdy;
            if (junk) begin
                iv[s] = 1'b1;
                in_data = 16'($urandom);
            end
            @(negedge clk);
            if (rdy) begin
                if (first_idx < 0) first_idx = exp_q[0];
                void'(exp_q.pop_front());
                n_hs++;
            end
        end
        iv[s] = 1'b0;
        ordy[s] = 1'b1;
        if (exp_q.size() > 0) check("scan timeout", guard, -1);
        check_idle("post");
        check("post last", int'(v_out_last), 0);
    endtask

    typedef struct {
        int          s;
        logic [15:0] vec;
        int          stall;
        bit          junk;
        int          exp_first;
        int          exp_cnt;
    } vec_t;

    initial begin
        vec_t tbl[7];
        int fi, nh;

        for (int i = 0; i < 3; i++) begin
            iv[i] = 1'b0;
            ordy[i] = 1'b1;
        end

        tbl[0] = '{0, 16'h00A4, 0, 1'b0, 7, 3};
        tbl[1] = '{0, 16'h00A4, 3, 1'b0, 7, 3};
        tbl[2] = '{0, 16'h0000, 0, 1'b0, -1, 0};
        tbl[3] = '{1, 16'h0083, 0, 1'b0, 0, 3};
        tbl[4] = '{2, 16'h8000, 0, 1'b1, 15, 1};
        tbl[5] = '{1, 16'h0080, 2, 1'b0, 7, 1};
        tbl[6] = '{2, 16'h0001, 0, 1'b1, 0, 1};

        // Reset state.
        repeat (2) @(negedge clk);
        sel = 0;
        check_idle("reset");
        check("reset index", int'(v_index), 0);
        check("reset last", int'(v_out_last), 0);
        check("reset none", int'(v_out_none), 0);
        reset = 1'b0;

        for (int t = 0; t < 7; t++) begin
            run_vec(tbl[t].s, tbl[t].vec, tbl[t].stall, 1'b0, tbl[t].junk, fi, nh);
            check($sformatf("tbl%0d first", t), fi, tbl[t].exp_first);
            check($sformatf("tbl%0d count", t), nh, tbl[t].exp_cnt);
        end

        // Reset in mid-scan with a handshake pending in the same cycle.
        sel = 0;
        @(negedge clk);
        in_data = 16'h00FF;
        iv[0] = 1'b1;
        @(negedge clk);
        iv[0] = 1'b0;
        check("rst first idx", int'(v_index), 7);
        ordy[0] = 1'b1;
        @(negedge clk);
        check("rst second idx", int'(v_index), 6);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_idle("after reset");
        check("after reset last", int'(v_out_last), 0);
        @(negedge clk);
        check_idle("after reset +1");
        run_vec(0, 16'h0010, 0, 1'b0, 1'b0, fi, nh);
        check("post-reset first", fi, 4);
        check("post-reset count", nh, 1);

        // Randomised vectors and back-pressure across all instances.
        for (int r = 0; r < 60; r++) begin
            int s;
            logic [15:0] v;
            s = $urandom_range(0, 2);
            v = 16'($urandom);
            if (s != 2) v[15:8] = '0;
            if ($urandom_range(0, 7) == 0) v = '0;
            run_vec(s, v, 0, 1'b1, 1'($urandom_range(0, 1)), fi, nh);
            check("rand count", nh, $countones(s == 2 ? v : {8'h00, v[7:0]}));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
